// File: rtl/power_emu_pkg.sv
// Shared types, LFSR tap table, seed and sizing helpers for the power emulator.
package power_emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } emu_state_t;

  localparam int LFSR_MIN_WIDTH = 2;
  localparam int LFSR_MAX_WIDTH = 16;
  localparam logic [LFSR_MAX_WIDTH-1:0] LFSR_SEED = 16'hFFFF;

  // Maximal-length feedback taps; bit k set means mask[k] feeds the XOR.
  function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int width);
    case (width)
      2:       lfsr_taps = 16'h0003;
      3:       lfsr_taps = 16'h0006;
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  function automatic int power_max(input int cges, input int bits);
    return $clog2(cges) + bits;
  endfunction

  // Operand count left after a number of 3:2 compression levels.
  function automatic int csa_count(input int n, input int levels);
    int c;
    c = n;
    for (int l = 0; l < levels; l++) begin
      if (c > 2) c = 2 * (c / 3) + (c % 3);
    end
    return c;
  endfunction

  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 2) begin
      c = 2 * (c / 3) + (c % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/power_emu_ppa_kogge_stone.sv
// Kogge-Stone parallel-prefix adder, carry-in 0, carry-out discarded.
module ppa_kogge_stone #(
  parameter int WIDTH = 36
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] w_g [LEVELS+1];
  logic [WIDTH-1:0] w_p [LEVELS+1];

  assign w_g[0] = a & b;
  assign w_p[0] = a ^ b;

  // Level k merges each bit with the group 2^k positions below it.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int DIST = 1 << k;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= DIST) begin : g_merge
        assign w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-DIST]);
        assign w_p[k+1][i] = w_p[k][i] & w_p[k][i-DIST];
      end else begin : g_pass
        assign w_g[k+1][i] = w_g[k][i];
        assign w_p[k+1][i] = w_p[k][i];
      end
    end
  end

  assign sum = w_p[0] ^ {w_g[LEVELS][WIDTH-2:0], 1'b0};

endmodule

// File: rtl/power_emulator_top.sv
// Cycle-based power emulator: LFSR-driven gate mask, CSA tree plus CPA into a registered sum.
// Define POWER_EMU_PPA_KS_EN to use the Kogge-Stone CPA instead of a behavioural adder.
module power_emulator_top
  import power_emu_pkg::*;
#(
  parameter  int              BITS      = 32,
  parameter  int              CGES      = 13,
  parameter  logic [BITS-1:0] CGE_POWER = 32'hFFFF_FFFF,
  localparam int              MAX       = power_max(CGES, BITS)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           fin,
  output logic [MAX-1:0] result
);

  localparam int                        LEVELS    = csa_levels(CGES);
  localparam logic [LFSR_MAX_WIDTH-1:0] TAPS_FULL = lfsr_taps(CGES);
  localparam logic [CGES-1:0]           TAPS      = TAPS_FULL[CGES-1:0];
  localparam logic [CGES-1:0]           SEED      = LFSR_SEED[CGES-1:0];

  emu_state_t      r_state;
  logic [CGES-1:0] r_mask;
  logic [MAX-1:0]  r_result;

  logic            w_fb;
  logic [MAX-1:0]  w_ops [LEVELS+1][CGES];
  logic [MAX-1:0]  w_vs;
  logic [MAX-1:0]  w_vc;
  logic [MAX-1:0]  w_sum;

  assign w_fb = ^(r_mask & TAPS);

  for (genvar i = 0; i < CGES; i++) begin : g_gate
    assign w_ops[0][i] = r_mask[i] ? {{(MAX-BITS){1'b0}}, CGE_POWER} : '0;
  end

  // Each level compresses groups of three operands into a sum and a shifted carry.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N   = csa_count(CGES, l);
    localparam int G   = N / 3;
    localparam int R   = N % 3;
    localparam int NXT = 2 * G + R;
    for (genvar g = 0; g < G; g++) begin : g_csa
      assign w_ops[l+1][2*g]   = w_ops[l][3*g] ^ w_ops[l][3*g+1] ^ w_ops[l][3*g+2];
      assign w_ops[l+1][2*g+1] = {((w_ops[l][3*g]   & w_ops[l][3*g+1]) |
                                   (w_ops[l][3*g]   & w_ops[l][3*g+2]) |
                                   (w_ops[l][3*g+1] & w_ops[l][3*g+2])), 1'b0} >> 0;
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign w_ops[l+1][2*G+r] = w_ops[l][3*G+r];
    end
    for (genvar u = NXT; u < CGES; u++) begin : g_unused
      assign w_ops[l+1][u] = '0;
    end
  end

  assign w_vs = w_ops[LEVELS][0];
  assign w_vc = w_ops[LEVELS][1];

`ifdef POWER_EMU_PPA_KS_EN
  ppa_kogge_stone #(
    .WIDTH (MAX)
  ) u_cpa (
    .a   (w_vs),
    .b   (w_vc),
    .sum (w_sum)
  );
`else
  assign w_sum = w_vs + w_vc;
`endif

  // Run control: fin wins over start, and a finished run needs both inputs low to rearm.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_mask   <= SEED;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !fin) begin
            r_state <= RUN;
            r_mask  <= SEED;
          end
        end
        RUN: begin
          if (fin) begin
            r_state <= DONE;
          end else begin
            r_result <= w_sum;
            r_mask   <= {r_mask[CGES-2:0], w_fb};
          end
        end
        DONE: begin
          if (!start && !fin) begin
            r_state  <= IDLE;
            r_result <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_power_emulator_top.sv
// Directed plus long-run scoreboard bench for power_emulator_top against a popcount model.
module tb_power_emulator_top;

  localparam int              BITS      = 32;
  localparam int              CGES      = 13;
  localparam int              MAX       = 36;
  localparam logic [BITS-1:0] CGE_POWER = 32'hFFFF_FFFF;

  typedef struct {
    string          tag;
    logic [MAX-1:0] exp;
  } sbEntry_t;

  logic           clk = 1'b0;
  logic           resetN;
  logic           start;
  logic           fin;
  logic [MAX-1:0] result;

  sbEntry_t       sbQ[$];
  int             checks = 0;
  int             failures = 0;

  int             mState;
  logic [CGES-1:0] mMask;
  logic [MAX-1:0] mResult;

  power_emulator_top #(
    .BITS      (BITS),
    .CGES      (CGES),
    .CGE_POWER (CGE_POWER)
  ) dut (
    .clk     (clk),
    .reset_n (resetN),
    .start   (start),
    .fin     (fin),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [MAX-1:0] modelPower(input logic [CGES-1:0] m);
    logic [MAX-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CGES; i++) cnt = cnt + {{(MAX-1){1'b0}}, m[i]};
    return cnt * {{(MAX-BITS){1'b0}}, CGE_POWER};
  endfunction

  function automatic logic [CGES-1:0] modelLfsr(input logic [CGES-1:0] m);
    return {m[CGES-2:0], m[12] ^ m[3] ^ m[2] ^ m[0]};
  endfunction

  task automatic compare(input string tag, input logic [MAX-1:0] observed, input logic [MAX-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    sbEntry_t e;
    @(negedge clk);
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", result);
    end else begin
      e = sbQ.pop_front();
      compare(e.tag, result, e.exp);
    end
  endtask

  // Drive inputs, advance the model through the coming edge, then check after it.
  task automatic applyStimulus(input logic rn, input logic st, input logic fn, input string tag);
    resetN = rn;
    start  = st;
    fin    = fn;
    if (!rn) begin
      mState  = 0;
      mResult = '0;
      mMask   = '1;
    end else begin
      case (mState)
        0: if (st && !fn) begin
             mState = 1;
             mMask  = '1;
           end
        1: if (fn) begin
             mState = 2;
           end else begin
             mResult = modelPower(mMask);
             mMask   = modelLfsr(mMask);
           end
        default: if (!st && !fn) begin
             mState  = 0;
             mResult = '0;
           end
      endcase
    end
    sbQ.push_back('{tag, mResult});
    @(posedge clk);
    checkOutput();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    start  = 1'b0;
    fin    = 1'b0;
    mState = 0;
    mMask  = '1;
    mResult = '0;

    applyStimulus(0, 0, 0, "reset0");
    applyStimulus(0, 0, 0, "reset1");
    compare("reset_zero", result, 36'h0);

    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, "idle_hold");
    compare("idle_zero", result, 36'h0);

    applyStimulus(1, 1, 0, "enter_run");
    compare("edge1", result, 36'h0);
    applyStimulus(1, 1, 0, "run_e2");
    compare("edge2_seed", result, 36'hC_FFFF_FFF3);
    applyStimulus(1, 1, 0, "run_e3");
    compare("edge3", result, 36'hB_FFFF_FFF4);

    applyStimulus(1, 1, 1, "fin_edge");
    compare("fin_freeze", result, 36'hB_FFFF_FFF4);
    applyStimulus(1, 1, 1, "done_hold");
    applyStimulus(1, 1, 0, "done_start_high");
    applyStimulus(1, 1, 0, "done_start_high2");
    compare("done_no_restart", result, 36'hB_FFFF_FFF4);

    applyStimulus(1, 0, 0, "to_idle");
    compare("clear_on_idle", result, 36'h0);

    applyStimulus(1, 1, 0, "restart_enter");
    applyStimulus(1, 1, 0, "restart_e2");
    compare("restart_seed", result, 36'hC_FFFF_FFF3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, "restart_run");

    applyStimulus(0, 1, 0, "mid_reset");
    compare("mid_reset_zero", result, 36'h0);
    applyStimulus(1, 1, 0, "resume_enter");
    compare("resume_edge1", result, 36'h0);
    applyStimulus(1, 1, 0, "resume_e2");
    compare("resume_seed", result, 36'hC_FFFF_FFF3);

    for (int i = 0; i < 10000; i++) applyStimulus(1, 1, 0, "long_run");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0, "random_ctrl");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
